// File: rtl/pwm_generator_dt.sv
// NCH-channel symmetric-carrier PWM with shadowed compare/period/dead-time and dead-band insertion.
// Gates lag the carrier by one cycle; there is no flow control, and inputs are sampled every cycle.
module pwm_generator_dt #(
  parameter int WIDTH = 16,
  parameter int NCH   = 3,
  parameter int DT_W  = 8
) (
  input  logic                 CLK,
  input  logic                 ARESETN,
  input  logic                 EN,
  input  logic [WIDTH-1:0]     PERIOD,
  input  logic [DT_W-1:0]      DEADTIME,
  input  logic [NCH*WIDTH-1:0] REF,
  input  logic [1:0]           UPD_MODE,
  input  logic                 LOAD,
  output logic [NCH-1:0]       PWM_H,
  output logic [NCH-1:0]       PWM_L,
  output logic [WIDTH-1:0]     CARRIER,
  output logic                 CARRIER_PEAK,
  output logic                 CARRIER_VALL,
  output logic                 INTR
);

  localparam logic [WIDTH-1:0] CNT_ONE = WIDTH'(1);
  localparam logic [DT_W-1:0]  DT_ONE  = DT_W'(1);

  typedef enum logic [1:0] {ST_DEAD, ST_HIGH, ST_LOW} state_t;

  logic [WIDTH-1:0]     cnt, cnt_n;
  logic                 dir_up, dir_n;
  logic [WIDTH-1:0]     period_s;
  logic [NCH*WIDTH-1:0] ref_s;
  logic [DT_W-1:0]      dt_s;
  logic                 en_q;
  logic                 first;
  logic                 sel_event;

  assign CARRIER      = cnt;
  assign CARRIER_PEAK = EN & dir_up & (cnt == period_s);
  assign CARRIER_VALL = EN & ~dir_up & (cnt == '0);
  assign first        = EN & ~en_q;

  always_comb begin
    sel_event = 1'b0;
    case (UPD_MODE)
      2'b00:   sel_event = CARRIER_VALL;
      2'b01:   sel_event = CARRIER_PEAK;
      default: sel_event = CARRIER_PEAK | CARRIER_VALL;
    endcase
  end

  // A zero period degenerates to a stationary carrier whose direction toggles,
  // so peak and valley events alternate every cycle.
  always_comb begin
    cnt_n = cnt;
    dir_n = dir_up;
    if (!EN) begin
      cnt_n = '0;
      dir_n = 1'b1;
    end else if (period_s == '0) begin
      cnt_n = '0;
      dir_n = ~dir_up;
    end else if (dir_up) begin
      if (cnt >= period_s) begin
        cnt_n = cnt - CNT_ONE;
        dir_n = 1'b0;
      end else begin
        cnt_n = cnt + CNT_ONE;
      end
    end else if (cnt == '0) begin
      cnt_n = CNT_ONE;
      dir_n = 1'b1;
    end else begin
      cnt_n = cnt - CNT_ONE;
    end
  end

  always_ff @(posedge CLK or negedge ARESETN) begin
    if (!ARESETN) begin
      cnt      <= '0;
      dir_up   <= 1'b1;
      period_s <= '0;
      ref_s    <= '0;
      dt_s     <= '0;
      en_q     <= 1'b0;
      INTR     <= 1'b0;
    end else begin
      cnt    <= cnt_n;
      dir_up <= dir_n;
      en_q   <= EN;
      INTR   <= sel_event;
      if (LOAD || sel_event) begin
        period_s <= PERIOD;
        ref_s    <= REF;
        dt_s     <= DEADTIME;
      end
    end
  end

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    state_t          state, state_n;
    logic            raw, raw_q, raw_q_n;
    logic [DT_W-1:0] dcnt, dcnt_n;
    logic            h_q, l_q;

    assign raw      = ref_s[i*WIDTH +: WIDTH] > cnt;
    assign PWM_H[i] = h_q;
    assign PWM_L[i] = l_q;

    // Any comparator edge, including the first enabled cycle, restarts the dead band.
    always_comb begin
      state_n = state;
      raw_q_n = raw_q;
      dcnt_n  = dcnt;
      if (!EN) begin
        state_n = ST_DEAD;
        dcnt_n  = '0;
      end else if (first || (raw != raw_q)) begin
        raw_q_n = raw;
        if (dt_s == '0) begin
          state_n = raw ? ST_HIGH : ST_LOW;
        end else begin
          state_n = ST_DEAD;
          dcnt_n  = dt_s;
        end
      end else if (state == ST_DEAD) begin
        if (dcnt <= DT_ONE) begin
          state_n = raw_q ? ST_HIGH : ST_LOW;
          dcnt_n  = '0;
        end else begin
          dcnt_n = dcnt - DT_ONE;
        end
      end
    end

    always_ff @(posedge CLK or negedge ARESETN) begin
      if (!ARESETN) begin
        state <= ST_DEAD;
        raw_q <= 1'b0;
        dcnt  <= '0;
        h_q   <= 1'b0;
        l_q   <= 1'b0;
      end else begin
        state <= state_n;
        raw_q <= raw_q_n;
        dcnt  <= dcnt_n;
        h_q   <= (state_n == ST_HIGH);
        l_q   <= (state_n == ST_LOW);
      end
    end
  end

endmodule

// File: tb/tb_pwm_generator_dt.sv
// Bench for pwm_generator_dt: directed scenarios then random traffic against a cycle reference model.
module tb_pwm_generator_dt;
  localparam int W = 16;
  localparam int N = 3;
  localparam int D = 8;

  logic         CLK = 1'b0;
  logic         ARESETN;
  logic         EN;
  logic [W-1:0] PERIOD;
  logic [D-1:0] DEADTIME;
  logic [N*W-1:0] REF;
  logic [1:0]   UPD_MODE;
  logic         LOAD;
  logic [N-1:0] PWM_H;
  logic [N-1:0] PWM_L;
  logic [W-1:0] CARRIER;
  logic         CARRIER_PEAK;
  logic         CARRIER_VALL;
  logic         INTR;

  pwm_generator_dt #(.WIDTH(W), .NCH(N), .DT_W(D)) dut (
    .CLK(CLK), .ARESETN(ARESETN), .EN(EN), .PERIOD(PERIOD), .DEADTIME(DEADTIME),
    .REF(REF), .UPD_MODE(UPD_MODE), .LOAD(LOAD), .PWM_H(PWM_H), .PWM_L(PWM_L),
    .CARRIER(CARRIER), .CARRIER_PEAK(CARRIER_PEAK), .CARRIER_VALL(CARRIER_VALL), .INTR(INTR)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int fails  = 0;

  // Reference model: carrier position plus, per channel, the last comparator
  // level and the number of cycles elapsed since it last changed.
  int m_cnt;
  bit m_up;
  int m_per;
  int m_ref [N];
  int m_dt;
  bit m_intr;
  bit m_enq;
  bit m_rawq [N];
  int m_since [N];
  int m_dtl [N];
  bit m_h [N];
  bit m_l [N];

  int seq [10] = '{1, 2, 3, 4, 3, 2, 1, 0, 1, 2};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_cnt = 0; m_up = 1'b1; m_per = 0; m_dt = 0; m_intr = 1'b0; m_enq = 1'b0;
    for (int i = 0; i < N; i++) begin
      m_ref[i] = 0; m_rawq[i] = 1'b0; m_since[i] = 0; m_dtl[i] = 0;
      m_h[i] = 1'b0; m_l[i] = 1'b0;
    end
  endtask

  task automatic check_regs();
    chk("carrier", CARRIER, m_cnt);
    chk("intr", INTR, m_intr);
    chk("no_overlap", PWM_H & PWM_L, 0);
    for (int i = 0; i < N; i++) begin
      chk($sformatf("pwm_h%0d", i), PWM_H[i], m_h[i]);
      chk($sformatf("pwm_l%0d", i), PWM_L[i], m_l[i]);
    end
  endtask

  task automatic set_ref(input int ch, input int val);
    REF[ch*W +: W] = val[W-1:0];
  endtask

  // One clock: check combinational events, advance the model, check registered outputs.
  task automatic step();
    bit en, peak, vall, sel;
    bit raw [N];
    int n_cnt;
    bit n_up;
    #1;
    en   = EN;
    peak = en && m_up && (m_cnt == m_per);
    vall = en && !m_up && (m_cnt == 0);
    chk("peak", CARRIER_PEAK, peak);
    chk("vall", CARRIER_VALL, vall);
    case (UPD_MODE)
      2'b00:   sel = vall;
      2'b01:   sel = peak;
      default: sel = peak || vall;
    endcase
    for (int i = 0; i < N; i++) raw[i] = m_ref[i] > m_cnt;

    n_cnt = m_cnt;
    n_up  = m_up;
    if (!en) begin
      n_cnt = 0; n_up = 1'b1;
    end else if (m_per == 0) begin
      n_cnt = 0; n_up = !m_up;
    end else begin
      if (m_up && m_cnt >= m_per) n_up = 1'b0;
      else if (!m_up && m_cnt == 0) n_up = 1'b1;
      n_cnt = n_up ? m_cnt + 1 : m_cnt - 1;
    end

    for (int i = 0; i < N; i++) begin
      if (en && (!m_enq || raw[i] != m_rawq[i])) begin
        m_rawq[i] = raw[i]; m_since[i] = 0; m_dtl[i] = m_dt;
      end else begin
        m_since[i]++;
      end
      m_h[i] = en && m_rawq[i] && (m_since[i] >= m_dtl[i]);
      m_l[i] = en && !m_rawq[i] && (m_since[i] >= m_dtl[i]);
    end

    if (LOAD || sel) begin
      m_per = PERIOD;
      m_dt  = DEADTIME;
      for (int i = 0; i < N; i++) m_ref[i] = REF[i*W +: W];
    end
    m_intr = sel;
    m_enq  = en;
    m_cnt  = n_cnt;
    m_up   = n_up;

    @(posedge CLK);
    #1;
    check_regs();
  endtask

  task automatic do_reset();
    ARESETN = 1'b0;
    #2;
    model_reset();
    check_regs();
    @(negedge CLK);
    ARESETN = 1'b1;
  endtask

  task automatic load_step();
    LOAD = 1'b1;
    step();
    LOAD = 1'b0;
  endtask

  initial begin
    EN = 1'b0; LOAD = 1'b0; PERIOD = '0; DEADTIME = '0; REF = '0; UPD_MODE = 2'b00;
    ARESETN = 1'b0;
    #3;
    model_reset();
    check_regs();
    @(negedge CLK);
    ARESETN = 1'b1;

    // Triangle carrier, single channel with zero dead time
    PERIOD = 16'd4;
    set_ref(0, 2);
    load_step();
    EN = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      chk("carrier_seq", CARRIER, seq[i]);
    end
    repeat (10) step();

    // Dead band of three cycles
    DEADTIME = 8'd3;
    set_ref(1, 3);
    set_ref(2, 1);
    load_step();
    repeat (30) step();

    // Peak-only updates with a mid-ramp compare change
    UPD_MODE = 2'b01;
    repeat (5) step();
    set_ref(0, 4);
    repeat (20) step();
    set_ref(0, 1);
    repeat (20) step();

    // Compare extremes and zero period
    set_ref(0, 0);
    set_ref(1, 5);
    load_step();
    repeat (20) step();
    PERIOD = 16'd0;
    UPD_MODE = 2'b10;
    load_step();
    repeat (10) step();

    // Disable and reset mid-period
    PERIOD = 16'd6;
    set_ref(0, 3);
    load_step();
    repeat (15) step();
    EN = 1'b0;
    repeat (4) step();
    EN = 1'b1;
    repeat (20) step();
    do_reset();
    repeat (6) step();
    load_step();
    repeat (20) step();

    // Random traffic
    for (int k = 0; k < 1500; k++) begin
      if ($urandom_range(39, 0) == 0) PERIOD = 16'($urandom_range(12, 0));
      if ($urandom_range(29, 0) == 0) DEADTIME = 8'($urandom_range(5, 0));
      if ($urandom_range(9, 0) == 0)
        set_ref(int'($urandom_range(N-1, 0)), int'($urandom_range(int'(PERIOD) + 2, 0)));
      if ($urandom_range(59, 0) == 0) UPD_MODE = 2'($urandom_range(3, 0));
      LOAD = ($urandom_range(24, 0) == 0);
      EN   = ($urandom_range(99, 0) >= 3);
      if ($urandom_range(499, 0) == 0) do_reset();
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
